// File: rtl/seq_checker.sv
// Receive-side integrity monitor for the cyclic sequence 0->6->1->4->3->0.
// Hunts for lock, flags deviations while locked (flywheeling the prediction), drops lock on repeated misses.
module seq_checker #(
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_val,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       expected,
  output logic [1:0]       state
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_HUNT   = 2'd1;
  localparam logic [1:0]       S_LOCKED = 2'd2;
  localparam logic [3:0]       LOCK_C   = 4'(LOCK_N);
  localparam logic [3:0]       UNLOCK_C = 4'(UNLOCK_N);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [2:0] nxt(input logic [2:0] v);
    case (v)
      3'd0:    nxt = 3'd6;
      3'd6:    nxt = 3'd1;
      3'd1:    nxt = 3'd4;
      3'd4:    nxt = 3'd3;
      3'd3:    nxt = 3'd0;
      default: nxt = 3'd1;
    endcase
  endfunction

  logic [1:0]       state_r, state_s;
  logic [2:0]       prev_r, prev_s;
  logic [3:0]       match_cnt_r, match_cnt_s;
  logic [3:0]       miss_cnt_r, miss_cnt_s;
  logic             locked_r, locked_s;
  logic             err_r, err_s;
  logic [CNT_W-1:0] err_count_r, err_count_s;
  logic [2:0]       expected_r, expected_s;
  logic             hit_s;

  assign hit_s = (in_val == nxt(prev_r));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and sequence-tracking registers' next values
  always_comb begin
    state_s     = state_r;
    prev_s      = prev_r;
    match_cnt_s = match_cnt_r;
    miss_cnt_s  = miss_cnt_r;
    if (in_valid) begin
      case (state_r)
        S_IDLE: begin
          prev_s      = in_val;
          match_cnt_s = 4'd0;
          state_s     = S_HUNT;
        end
        S_HUNT: begin
          prev_s = in_val;
          if (hit_s) begin
            match_cnt_s = match_cnt_r + 4'd1;
            if (match_cnt_s == LOCK_C) begin
              state_s    = S_LOCKED;
              miss_cnt_s = 4'd0;
            end else begin
              state_s = S_HUNT;
            end
          end else begin
            match_cnt_s = 4'd0;
          end
        end
        S_LOCKED: begin
          if (hit_s) begin
            miss_cnt_s = 4'd0;
            prev_s     = in_val;
          end else begin
            miss_cnt_s = miss_cnt_r + 4'd1;
            if (miss_cnt_s == UNLOCK_C) begin
              state_s     = S_HUNT;
              prev_s      = in_val;
              match_cnt_s = 4'd0;
              miss_cnt_s  = 4'd0;
            end else begin
              // Flywheel: keep predicting from the trusted history, ignore the bad sample
              prev_s = nxt(prev_r);
            end
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Next values of the registered outputs
  always_comb begin
    err_s      = in_valid && (state_r == S_LOCKED) && !hit_s;
    locked_s   = (state_s == S_LOCKED);
    expected_s = expected_r;
    if (in_valid) begin
      expected_s = nxt(prev_s);
    end else begin
      expected_s = expected_r;
    end
    err_count_s = err_count_r;
    if (clr_cnt) begin
      err_count_s = err_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (err_s && (err_count_r != CNT_MAX)) begin
      err_count_s = err_count_r + CNT_ONE;
    end else begin
      err_count_s = err_count_r;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r      <= 3'd0;
      match_cnt_r <= 4'd0;
      miss_cnt_r  <= 4'd0;
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= {CNT_W{1'b0}};
      expected_r  <= 3'd0;
    end else begin
      prev_r      <= prev_s;
      match_cnt_r <= match_cnt_s;
      miss_cnt_r  <= miss_cnt_s;
      locked_r    <= locked_s;
      err_r       <= err_s;
      err_count_r <= err_count_s;
      expected_r  <= expected_s;
    end
  end

  assign state     = state_r;
  assign locked    = locked_r;
  assign err       = err_r;
  assign err_count = err_count_r;
  assign expected  = expected_r;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed plan steps plus a randomized phase,
// compared against a rule-level reference model. Two instances cover CNT_W=8 and CNT_W=2.
module tb_seq_checker;

  localparam int LOCK_N   = 3;
  localparam int UNLOCK_N = 2;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr_cnt;
  logic [2:0] in_val;

  logic       locked8, err8, locked2, err2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [2:0] exp8, exp2;
  logic [1:0] state8, state2;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int succ_tab [8] = '{6, 4, 1, 0, 3, 1, 1, 1};
  int m_state, m_prev, m_match, m_miss, m_cnt8, m_cnt2, m_exp;
  bit m_err;
  int src;

  always #5 clk = ~clk;

  seq_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val), .clr_cnt(clr_cnt),
    .locked(locked8), .err(err8), .err_count(cnt8), .expected(exp8), .state(state8));

  seq_checker #(.LOCK_N(LOCK_N), .UNLOCK_N(UNLOCK_N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val), .clr_cnt(clr_cnt),
    .locked(locked2), .err(err2), .err_count(cnt2), .expected(exp2), .state(state2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic model(input bit r, input bit v, input int val, input bit c);
    m_err = 1'b0;
    if (r) begin
      m_state = 0; m_prev = 0; m_match = 0; m_miss = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_exp = 0;
    end else begin
      if (v) begin
        case (m_state)
          0: begin
            m_prev = val; m_match = 0; m_state = 1;
          end
          1: begin
            if (val == succ_tab[m_prev]) begin
              m_match++;
              if (m_match == LOCK_N) begin m_state = 2; m_miss = 0; end
            end else begin
              m_match = 0;
            end
            m_prev = val;
          end
          default: begin
            if (val == succ_tab[m_prev]) begin
              m_miss = 0; m_prev = val;
            end else begin
              m_err = 1'b1;
              m_miss++;
              if (m_miss == UNLOCK_N) begin
                m_state = 1; m_prev = val; m_match = 0; m_miss = 0;
              end else begin
                m_prev = succ_tab[m_prev];
              end
            end
          end
        endcase
        m_exp = succ_tab[m_prev];
      end
      if (c) begin
        m_cnt8 = m_err; m_cnt2 = m_err;
      end else if (m_err) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit v, input int val, input bit c);
    rst = r; in_valid = v; in_val = 3'(val); clr_cnt = c;
    @(posedge clk);
    #1;
    model(r, v, val, c);
    chk("state",     32'(state8),  32'(m_state));
    chk("locked",    32'(locked8), 32'(m_state == 2));
    chk("err",       32'(err8),    32'(m_err));
    chk("err_count", 32'(cnt8),    32'(m_cnt8));
    chk("expected",  32'(exp8),    32'(m_exp));
    chk("state_w2",  32'(state2),  32'(m_state));
    chk("locked_w2", 32'(locked2), 32'(m_state == 2));
    chk("err_w2",    32'(err2),    32'(m_err));
    chk("cnt_w2",    32'(cnt2),    32'(m_cnt2));
    chk("exp_w2",    32'(exp2),    32'(m_exp));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_val = 3'd0; clr_cnt = 1'b0;
    m_state = 0; m_prev = 0; m_match = 0; m_miss = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_exp = 0; m_err = 1'b0;

    // Reset state
    cyc(1'b1, 1'b0, 0, 1'b0);
    chk("rst_state", 32'(state8), 32'd0);
    chk("rst_exp",   32'(exp8),   32'd0);

    // Plan 1: acquire lock on 0,6,1,4
    cyc(1'b0, 1'b1, 0, 1'b0);
    chk("t1_hunt", 32'(state8), 32'd1);
    cyc(1'b0, 1'b1, 6, 1'b0);
    cyc(1'b0, 1'b1, 1, 1'b0);
    chk("t1_not_yet", 32'(locked8), 32'd0);
    cyc(1'b0, 1'b1, 4, 1'b0);
    chk("t1_locked", 32'(locked8), 32'd1);
    chk("t1_exp",    32'(exp8),    32'd3);

    // Plan 2: single error while locked, flywheel prediction
    cyc(1'b0, 1'b1, 5, 1'b0);
    chk("t2_err",    32'(err8),    32'd1);
    chk("t2_cnt",    32'(cnt8),    32'd1);
    chk("t2_locked", 32'(locked8), 32'd1);
    chk("t2_exp",    32'(exp8),    32'd0);
    cyc(1'b0, 1'b1, 0, 1'b0);
    chk("t2_noerr",  32'(err8),    32'd0);
    chk("t2_exp2",   32'(exp8),    32'd6);

    // Plan 3: two consecutive errors drop lock, then relock
    cyc(1'b0, 1'b1, 2, 1'b0);
    chk("t3_err1",   32'(err8),    32'd1);
    cyc(1'b0, 1'b1, 2, 1'b0);
    chk("t3_err2",   32'(err8),    32'd1);
    chk("t3_cnt",    32'(cnt8),    32'd3);
    chk("t3_unlock", 32'(locked8), 32'd0);
    chk("t3_hunt",   32'(state8),  32'd1);
    chk("t3_exp",    32'(exp8),    32'd1);
    cyc(1'b0, 1'b1, 1, 1'b0);
    cyc(1'b0, 1'b1, 4, 1'b0);
    cyc(1'b0, 1'b1, 3, 1'b0);
    chk("t3_relock", 32'(locked8), 32'd1);

    // Plan 4: in_valid low freezes everything
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, int'($urandom_range(0, 7)), 1'b0);
      chk("t4_hold_exp", 32'(exp8), 32'd0);
      chk("t4_hold_cnt", 32'(cnt8), 32'd3);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, m_exp, 1'b0);
      chk("t4_resume_err", 32'(err8), 32'd0);
    end

    // Plan 5: saturation of the 2-bit counter, clear coinciding with error
    cyc(1'b0, 1'b0, 0, 1'b1);
    chk("t5_clr", 32'(cnt8), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 7, 1'b0);
      chk("t5_sat_w2", 32'(cnt2), 32'((i < 2) ? i + 1 : 3));
      cyc(1'b0, 1'b1, m_exp, 1'b0);
    end
    chk("t5_cnt8", 32'(cnt8), 32'd5);
    cyc(1'b0, 1'b1, 7, 1'b1);
    chk("t5_clr_err_w2", 32'(cnt2), 32'd1);
    chk("t5_clr_err",    32'(cnt8), 32'd1);
    cyc(1'b0, 1'b1, m_exp, 1'b0);

    // Plan 6: reset while locked with errors on the books
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 7, 1'b0);
      cyc(1'b0, 1'b1, m_exp, 1'b0);
    end
    chk("t6_cnt4",   32'(cnt8),    32'd4);
    chk("t6_locked", 32'(locked8), 32'd1);
    cyc(1'b1, 1'b1, 7, 1'b0);
    chk("t6_state",  32'(state8),  32'd0);
    chk("t6_locked0", 32'(locked8), 32'd0);
    chk("t6_cnt0",   32'(cnt8),    32'd0);
    chk("t6_exp0",   32'(exp8),    32'd0);
    chk("t6_err0",   32'(err8),    32'd0);

    // Randomized phase: mostly-correct source with corruption, gaps, clears and rare resets
    src = 0;
    for (int i = 0; i < 800; i++) begin
      int r_sel;
      int val;
      bit v;
      r_sel = int'($urandom_range(0, 199));
      v = ($urandom_range(0, 3) != 0);
      val = ($urandom_range(0, 9) < 8) ? src : int'($urandom_range(0, 7));
      if (v) src = succ_tab[src];
      cyc((r_sel == 0), v, val, (r_sel < 4) && (r_sel != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
Receive-side monitor for the 3-bit cyclic sequence 0->6->1->4->3->0 produced by the team's sequence counter.
- Samples a 3-bit value on each valid cycle and predicts the next value.
- Acquires lock after a run of correct transitions, then flags and counts deviations.
- Drops lock after repeated consecutive errors.
- Sits downstream of the counter, or of any link carrying it, as a link/sequence integrity checker.

Parameters:
LOCK_N, 3, consecutive correct transitions in HUNT required to enter LOCKED (1..15)
UNLOCK_N, 2, consecutive mismatches in LOCKED required to drop to HUNT (1..15)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_val is sampled this cycle when high
in_val  input  3  observed sequence value
clr_cnt  input  1  synchronous clear of err_count
locked  output  1  high while in LOCKED
err  output  1  one-cycle pulse: mismatch detected while LOCKED
err_count  output  CNT_W  saturating count of err pulses
expected  output  3  predicted value of the next valid sample
state  output  2  0=IDLE, 1=HUNT, 2=LOCKED (3 unused)

Behaviour:
- Reset: synchronous on rst=1 at a clk edge; takes priority over every other input.
  - Values after reset: state=IDLE, locked=0, err=0, err_count=0, expected=0.
  - Internal registers cleared: prev=0, match_cnt=0, miss_cnt=0.
  - rst asserted mid-lock behaves identically: all of the above take effect at the next edge.
- Successor function nxt(v):
  - 0->6, 6->1, 1->4, 4->3, 3->0.
  - Any other value (2, 5, 7) -> 1.
- expected = nxt(prev), registered. It is updated at the same edge as prev and is therefore valid the cycle after the sample.
- in_valid=0: no state, prev or counter change; err=0.
- All outputs are registered and reflect a sample one cycle after the edge that captured it.
- IDLE: on a valid sample, prev<=in_val (any value), match_cnt<=0, go to HUNT. No err.
- HUNT: on a valid sample:
  - If in_val==nxt(prev): match_cnt++. If match_cnt reaches LOCK_N, go to LOCKED with miss_cnt<=0.
  - Else: match_cnt<=0 (resync).
  - In both cases prev<=in_val. err is never asserted in HUNT.
- LOCKED: on a valid sample:
  - Match: miss_cnt<=0, prev<=in_val.
  - Mismatch:
    - err=1 for one cycle, err_count increments, miss_cnt++.
    - Flywheel: prev<=nxt(prev), so the prediction keeps advancing and ignores the bad value.
    - If miss_cnt reaches UNLOCK_N: go to HUNT with prev<=in_val, match_cnt<=0, miss_cnt<=0, locked<=0.
  - The err pulse and count increment occur on the unlocking sample as well.
- locked=1 exactly when state==LOCKED.
- err_count:
  - Saturates at 2^CNT_W-1; never wraps.
  - clr_cnt takes effect in any state.
  - clr_cnt and an error in the same cycle: err_count<=1.
  - clr_cnt with no error: err_count<=0.
- Internal counters match_cnt and miss_cnt are 4 bits wide.

Test Plan:
1. rst, then valid samples 0,6,1,4 on consecutive cycles -> state IDLE->HUNT; locked=1 the cycle after sample 4; err=0 throughout; expected=3.
2. Locked at expected=3, feed 5 -> err=1 for one cycle, err_count=1, locked stays 1, expected=0. Then feed 0 -> no err, expected=6, miss_cnt cleared.
3. Locked at expected=6, feed 2 then 2 -> two err pulses, err_count+=2; after the second, locked=0, state=HUNT, expected=nxt(2)=1. Then feed 1,4,3 -> relock.
4. Locked, toggle in_val randomly with in_valid=0 for 5 cycles -> no change to state, expected or err_count. Then resume the correct sequence -> no errors.
5. CNT_W=2, locked, inject 5 isolated errors separated by correct samples -> err_count 1,2,3,3,3. Then clr_cnt together with a 6th error -> err_count=1.
6. Locked with err_count=4, assert rst for one cycle -> next cycle locked=0, state=IDLE, err_count=0, expected=0, err=0.
